// File: rtl/sinewave_lut_if.sv
// Phase-address / sine-sample bundle between a phase source and a sinewave_lut.
// The source drives address; the LUT returns the registered sample on value.
interface sinewave_lut_if #(
  parameter int DATA_WIDTH = 7,
  parameter int LUT_DEPTH  = 8
);
  logic        [LUT_DEPTH-1:0]  address;
  logic signed [DATA_WIDTH-1:0] value;

  modport master (
    output address,
    input  value
  );

  modport slave (
    input  address,
    output value
  );
endinterface

// File: rtl/sinewave_lut.sv
// Quarter-wave sine ROM with quadrant folding; one registered signed sample per clock.
// ROM contents are built at elaboration from an integer Taylor-series constant function.
module sinewave_lut #(
  parameter int DATA_WIDTH = 7,
  parameter int LUT_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           arst_n,
  sinewave_lut_if.slave  lut
);

  localparam int     Q      = 1 << (LUT_DEPTH - 2);
  localparam int     MAG_W  = DATA_WIDTH - 1;
  localparam int     IDX_W  = LUT_DEPTH - 1;
  localparam longint AMP    = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(AMP * sin(pi*i/(2Q))) using Q30 fixed point, half rounded away from zero.
  function automatic longint quarter_sine(input int i);
    longint x;
    longint term;
    longint sum;
    longint res;
    x    = (PI_Q30 * longint'(i)) / longint'(2 * Q);
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    res = (AMP * sum + (64'sd1 <<< 29)) >>> 30;
    if (res < 64'sd0) begin
      res = 64'sd0;
    end else if (res > AMP) begin
      res = AMP;
    end else begin
      res = res;
    end
    return res;
  endfunction

  logic [MAG_W-1:0] rom_s [0:Q];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    localparam longint QV = quarter_sine(gi);
    assign rom_s[gi] = MAG_W'(QV);
  end

  logic        [LUT_DEPTH-1:0]  address_s;
  logic        [1:0]            quad_s;
  logic        [LUT_DEPTH-3:0]  k_s;
  logic        [IDX_W-1:0]      idx_s;
  logic        [DATA_WIDTH:0]   mag_ext_s;
  logic        [DATA_WIDTH:0]   neg_s;
  logic signed [DATA_WIDTH-1:0] value_d;
  logic signed [DATA_WIDTH-1:0] value_q;

  assign address_s = lut.address;
  assign lut.value = value_q;

  // Fold the address into the stored quarter and restore the sign per quadrant.
  always_comb begin
    quad_s    = address_s[LUT_DEPTH-1:LUT_DEPTH-2];
    k_s       = address_s[LUT_DEPTH-3:0];
    idx_s     = {1'b0, k_s};
    if (quad_s[0]) begin
      idx_s = IDX_W'(Q) - {1'b0, k_s};
    end else begin
      idx_s = {1'b0, k_s};
    end
    mag_ext_s = {2'b00, rom_s[idx_s]};
    // Negating a zero magnitude yields plain zero, so no negative-zero artefact.
    neg_s     = {(DATA_WIDTH + 1){1'b0}} - mag_ext_s;
    if (quad_s[1]) begin
      value_d = neg_s[DATA_WIDTH-1:0];
    end else begin
      value_d = mag_ext_s[DATA_WIDTH-1:0];
    end
  end

  // Output sample register; reset clears it without waiting for a clock.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      value_q <= {DATA_WIDTH{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: tb/tb_sinewave_lut.sv
// Directed bench for sinewave_lut: reset, cardinal/interior points, full sweep,
// async reset mid-sweep and a sin/cos quadrature pair.
module tb_sinewave_lut;

  localparam int DW = 7;
  localparam int LD = 8;

  logic clk;
  logic arst_n;
  int   checks;
  int   errors;
  int   sin_vals [0:255];
  int   cos_vals [0:255];

  sinewave_lut_if #(.DATA_WIDTH(DW), .LUT_DEPTH(LD)) sin_if ();
  sinewave_lut_if #(.DATA_WIDTH(DW), .LUT_DEPTH(LD)) cos_if ();

  sinewave_lut #(.DATA_WIDTH(DW), .LUT_DEPTH(LD)) u_sin (
    .clk    (clk),
    .arst_n (arst_n),
    .lut    (sin_if.slave)
  );

  sinewave_lut #(.DATA_WIDTH(DW), .LUT_DEPTH(LD)) u_cos (
    .clk    (clk),
    .arst_n (arst_n),
    .lut    (cos_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model(input int a);
    real r;
    r = 63.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
    if (r >= 0.0) return int'($floor(r + 0.5));
    else          return -int'($floor(-r + 0.5));
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a);
    sin_if.address = 8'(a);
    cos_if.address = 8'(a + 64);
  endtask

  // Apply an address, confirm the output has not moved yet, then expect it one edge later.
  task automatic apply(input string tag, input int a, input int prev, input int exp);
    drive(a);
    #1;
    check({tag, "_hold"}, 32'(sin_if.value), 32'(prev));
    @(posedge clk);
    #1;
    check(tag, 32'(sin_if.value), 32'(exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b0;
    drive(64);

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'(sin_if.value), 32'sd0);
    end
    arst_n = 1'b1;
    apply("reset_release", 64, 0, 63);

    apply("card_0",   0,   63,  0);
    apply("card_64",  64,  0,   63);
    apply("card_128", 128, 63,  0);
    apply("card_192", 192, 0,  -63);

    apply("int_16",  16,  -63,  24);
    apply("int_32",  32,   24,  45);
    apply("int_96",  96,   45,  45);
    apply("int_160", 160,  45, -45);
    apply("int_224", 224, -45, -45);
    apply("int_240", 240, -45, -24);

    for (int a = 0; a < 256; a++) begin
      drive(a);
      @(posedge clk);
      #1;
      sin_vals[a] = int'(sin_if.value);
      cos_vals[a] = int'(cos_if.value);
      check("sweep", 32'(sin_if.value), 32'(model(a)));
    end
    for (int a = 0; a < 128; a++) begin
      check("odd_sym", 32'(sin_vals[a]), 32'(-sin_vals[a + 128]));
    end
    for (int a = 0; a < 256; a++) begin
      check("min_bound", 32'(sin_vals[a] >= -63), 32'sd1);
      check("quad_cos", 32'(cos_vals[a]), 32'(model((a + 64) % 256)));
    end

    drive(0);
    @(posedge clk);
    #1;
    check("quad_sin0", 32'(sin_if.value), 32'sd0);
    check("quad_cos0", 32'(cos_if.value), 32'sd63);

    drive(64);
    @(posedge clk);
    #1;
    check("pre_reset", 32'(sin_if.value), 32'sd63);
    #1;
    arst_n = 1'b0;
    #1;
    check("async_rst_sin", 32'(sin_if.value), 32'sd0);
    check("async_rst_cos", 32'(cos_if.value), 32'sd0);
    arst_n = 1'b1;
    for (int a = 65; a < 100; a++) begin
      drive(a);
      @(posedge clk);
      #1;
      check("resume", 32'(sin_if.value), 32'(model(a)));
      check("resume_cos", 32'(cos_if.value), 32'(model((a + 64) % 256)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sinewave_lut.md
Name: sinewave_lut

Overview:
- Synchronous sine look-up table for the NCO datapath.
- Maps a phase address (top LUT_DEPTH bits of a phase accumulator) to a signed two's-complement sine sample.
- Two instances form a quadrature pair: one at the raw address, one at the address offset by a quarter period (cosine).
- Only a quarter-wave is stored; full-period values are derived by symmetry.

Parameters:
- DATA_WIDTH, 7, width of the signed output sample; amplitude A = 2^(DATA_WIDTH-1) - 1 (63 at default).
- LUT_DEPTH, 8, address width; one sine period = 2^LUT_DEPTH entries (256 at default). Legal range 3..12.

Ports:
- clk  input  1  rising-edge clock.
- arst_n  input  1  asynchronous reset, active-low.
- address  input  LUT_DEPTH  unsigned phase index, 0 .. 2^LUT_DEPTH - 1.
- value  output  DATA_WIDTH (signed)  registered sine sample.

Behaviour:
- Definitions: N = 2^LUT_DEPTH, Q = N/4.
- Ideal function: value(a) = round(A * sin(2*pi*a/N)), rounding half away from zero.
- Latency: exactly 1 clock. `value` presents the sample for the address sampled at the previous rising edge of clk. `address` is sampled every cycle; there is no enable.
- Reset: arst_n low forces `value` to 0 immediately, independent of clk, and holds it there. The first valid sample appears on the first rising edge after arst_n deasserts. Reset asserted mid-stream zeroes the output at once; no other state exists.
- Storage: a quarter-wave ROM of Q+1 entries, q[i] = round(A * sin(pi*i/(2Q))) for i = 0..Q. Entries are unsigned, q[0] = 0, q[Q] = A. Contents are computed at elaboration time, either by a constant function or a generated case table, so any legal parameter set works without hand edits.
- Quadrant decode: quadrant = address[LUT_DEPTH-1:LUT_DEPTH-2], offset k = address[LUT_DEPTH-3:0].
  - Quadrant 0: +q[k].
  - Quadrant 1: +q[Q-k].
  - Quadrant 2: -q[k].
  - Quadrant 3: -q[Q-k].
- Symmetry is exact by construction:
  - value(a) = -value(a+N/2) mod N.
  - value(a) = value(N/2 - a).
- Zero crossings: address 0 and N/2 both give exactly 0 (never a negative zero artefact). Peaks are +A at Q and -A at 3Q.
- Range: output never reaches -2^(DATA_WIDTH-1); the table is symmetric about 0.
- Negation is done in DATA_WIDTH+1 bits, then truncated. No overflow is possible because |value| <= A.
- Address wrap: N-1 is followed naturally by 0. The table has no discontinuity other than normal sine sampling.
- Purely synchronous datapath apart from the reset. No combinational path from address to value.

Test Plan:
- Reset: hold arst_n=0, toggle clk with address=64 -> value stays 0. Release arst_n, apply address=64 -> value=63 one edge later.
- Cardinal points (defaults): address 0,64,128,192 -> value 0,63,0,-63, each appearing exactly one clock after its address.
- Interior points: address 16 -> 24, 32 -> 45, 96 -> 45, 160 -> -45, 224 -> -45, 240 -> -24.
- Full sweep: address 0..255 every cycle against a real-arithmetic model with round-half-away-from-zero -> zero mismatches. Also check value(a) == -value(a+128) and that no output is below -63.
- Async reset mid-sweep: drop arst_n between edges while value=63 -> value=0 immediately with no clock edge. Release and resume the sweep -> values track the model with 1-cycle latency.
- Quadrature pair: two instances, second fed (address+64) mod 256, driven by accumulator steps of 1 -> cos output equals sin output shifted by 64 samples. At address 0, sin=0 and cos=63.
